flash_rom_loader: RTL and testbench

Boot-time copy engine that sits directly upstream of the dual-IO SPI flash reader. It issues byte reads through the reader's `cs`/`address` request interface and collects each byte from `dout` when `busy` falls. It then writes the bytes sequentially into the target ROM memory (BRAM or SDRAM port) through a write/acknowledge handshake. It holds the system in reset-equivalent state through `loading` until the ROM image (KERNAL/BASIC/character ROM) has been copied.

---
 rtl/flash_rom_loader_pkg.sv | 9 +
 rtl/flash_rom_loader.sv | 148 ++++++++++++++
 tb/tb_flash_rom_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/flash_rom_loader_pkg.sv
// flash_rom_loader_pkg: loader state encoding and handshake timeout limits.
package flash_rom_loader_pkg;
  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, REQ, WAIT_BUSY, WAIT_DONE, WRITE, NEXT, DONE, ERROR
  } state_t;
  localparam int BUSY_TIMEOUT = 8;
  localparam int XFER_TIMEOUT = 64;
  localparam int MAX_RETRY = 3;
endpackage

// File: rtl/flash_rom_loader.sv
// flash_rom_loader: copies a ROM image byte by byte from the SPI flash reader into target memory.
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h200000,
  parameter int LEN = 16384,
  parameter int ADDR_W = 14,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              flash_ready,
  output logic              flash_cs,
  output logic [23:0]       flash_addr,
  input  logic              flash_busy,
  input  logic [7:0]        flash_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              loading,
  output logic              done,
  output logic              error
);
  localparam logic [ADDR_W:0] CNT_LEN = (ADDR_W+1)'(LEN);
  state_t state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [1:0] retry_q, retry_d;
  logic [6:0] tmo_q, tmo_d;
  logic flash_cs_q, flash_cs_d, mem_we_q, mem_we_d;
  logic loading_q, loading_d, done_q, done_d, error_q, error_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic go;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    retry_d = retry_q;
    tmo_d = tmo_q;
    flash_cs_d = flash_cs_q;
    flash_addr_d = flash_addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d = mem_we_q;
    loading_d = loading_q;
    done_d = done_q;
    error_d = error_q;
    go = (state_q == IDLE && (AUTO_START || start)) || ((state_q == DONE || state_q == ERROR) && start);
    case (state_q)
      WAIT_RDY: state_d = flash_ready && !flash_busy ? REQ : WAIT_RDY;
      REQ: begin
        flash_cs_d = 1'b1;
        tmo_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + 7'd1;
        if (flash_busy) begin
          flash_cs_d = 1'b0;
          tmo_d = '0;
          state_d = WAIT_DONE;
        end else if (tmo_q == 7'(BUSY_TIMEOUT - 1)) begin
          // dropping cs for the REQ cycle gives the reader a fresh rising edge
          flash_cs_d = 1'b0;
          retry_d = retry_q + 2'd1;
          state_d = retry_d < 2'(MAX_RETRY) ? REQ : ERROR;
          error_d = retry_d >= 2'(MAX_RETRY);
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + 7'd1;
        if (!flash_busy) begin
          mem_data_d = flash_dout;
          mem_we_d = 1'b1;
          retry_d = '0;
          state_d = WRITE;
        end else if (tmo_q == 7'(XFER_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ERROR;
        end
      end
      WRITE: if (mem_ack) begin
        mem_we_d = 1'b0;
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        state_d = NEXT;
      end
      NEXT: if (cnt_q == CNT_LEN) begin
        loading_d = 1'b0;
        done_d = 1'b1;
        state_d = DONE;
      end else begin
        mem_addr_d = mem_addr_q + (ADDR_W)'(1);
        flash_addr_d = flash_addr_q + 24'd1;
        state_d = REQ;
      end
      default: ;
    endcase
    if (go) begin
      state_d = WAIT_RDY;
      cnt_d = '0;
      retry_d = '0;
      mem_addr_d = '0;
      flash_addr_d = FLASH_BASE;
      loading_d = 1'b1;
      done_d = 1'b0;
      error_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      retry_q <= '0;
      tmo_q <= '0;
      flash_cs_q <= 1'b0;
      flash_addr_q <= FLASH_BASE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q <= 1'b0;
      loading_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      tmo_q <= tmo_d;
      flash_cs_q <= flash_cs_d;
      flash_addr_q <= flash_addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q <= mem_we_d;
      loading_q <= loading_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign flash_cs = flash_cs_q;
  assign flash_addr = flash_addr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we = mem_we_q;
  assign loading = loading_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_flash_rom_loader.sv
// tb_flash_rom_loader: behavioural flash reader and write scoreboard around flash_rom_loader.
module tb_flash_rom_loader;
  localparam int LEN = 16;
  localparam int ADDR_W = 4;
  localparam logic [23:0] BASE = 24'h200000;
  logic clk = 1'b0, resetn, start, flash_ready, flash_cs, flash_busy, mem_we, mem_ack;
  logic loading, done, error;
  logic [23:0] flash_addr;
  logic [7:0] flash_dout, mem_data;
  logic [ADDR_W-1:0] mem_addr;
  int n_cmp = 0, n_bad = 0;
  int wr_idx = 0, cyc = 0, xfer_left = 0, ignore_left = 0, req5 = 0, cs_unready = 0;
  int hold_a, hold_d;
  bit hold_v = 0, hang_next = 0, ack_every4 = 0, cs_s1 = 0, cs_s2 = 0;
  logic [23:0] req_addr;
  flash_rom_loader #(.FLASH_BASE(BASE), .LEN(LEN), .ADDR_W(ADDR_W), .AUTO_START(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .flash_ready(flash_ready),
    .flash_cs(flash_cs), .flash_addr(flash_addr), .flash_busy(flash_busy), .flash_dout(flash_dout),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .loading(loading), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_cs"}, int'(flash_cs), 0);
    check({tag, "_faddr"}, int'(flash_addr), int'(BASE));
    check({tag, "_maddr"}, int'(mem_addr), 0);
    check({tag, "_mdata"}, int'(mem_data), 0);
    check({tag, "_we"}, int'(mem_we), 0);
    check({tag, "_loading"}, int'(loading), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
  endtask
  task automatic wait_end(input int max);
    int n = 0;
    while (!(done || error) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) check("wait_end_timeout", 1, 0);
  endtask
  task automatic check_done(input string tag);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_loading"}, int'(loading), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_count"}, wr_idx, LEN);
  endtask
  task automatic kick();
    wr_idx = 0;
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask
  // Reader model and write scoreboard share one process so inputs and checks see the same negedge.
  initial begin
    flash_busy = 1'b0;
    flash_dout = 8'h00;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ack = ack_every4 ? (cyc % 4 == 0) : 1'b1;
      cs_s2 = cs_s1;
      cs_s1 = flash_cs;
      if (xfer_left > 0) begin
        xfer_left--;
        flash_dout = 8'($urandom);
        if (xfer_left == 0) begin
          flash_busy = 1'b0;
          flash_dout = req_addr[7:0] ^ 8'hA5;
        end
      end else if (cs_s1 && !cs_s2 && flash_ready) begin
        req_addr = flash_addr;
        if (req_addr[7:0] == 8'd5) req5++;
        if (ignore_left > 0 && req_addr[7:0] == 8'd5) ignore_left--;
        else begin
          flash_busy = 1'b1;
          xfer_left = hang_next ? 70 : int'($urandom_range(3, 20));
          hang_next = 0;
        end
      end
      if (!resetn) hold_v = 0;
      else begin
        if (flash_cs && !flash_ready) cs_unready++;
        if (mem_we && hold_v) begin
          check("hold_addr", int'(mem_addr), hold_a);
          check("hold_data", int'(mem_data), hold_d);
        end
        if (mem_we && mem_ack) begin
          check("wr_in_range", int'(wr_idx < LEN), 1);
          check("wr_addr", int'(mem_addr), wr_idx % LEN);
          check("wr_data", int'(mem_data), int'(8'(BASE + 24'(wr_idx)) ^ 8'hA5));
          wr_idx++;
        end
        hold_v = mem_we && !mem_ack;
        hold_a = int'(mem_addr);
        hold_d = int'(mem_data);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    resetn = 1'b0;
    start = 1'b0;
    flash_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset("rst");
    resetn = 1'b1;
    repeat (100) @(posedge clk);
    #2 check("cs_unready", cs_unready, 0);
    check("loading_wait_rdy", int'(loading), 1);
    flash_ready = 1'b1;
    wait_end(3000);
    check_done("basic");
    ack_every4 = 1;
    kick();
    wait_end(4000);
    check_done("slow_ack");
    ack_every4 = 0;
    req5 = 0;
    ignore_left = 2;
    kick();
    wait_end(3000);
    check_done("retry2");
    check("retry2_reqs", req5, 3);
    ignore_left = 3;
    kick();
    wait_end(3000);
    check("retry3_error", int'(error), 1);
    check("retry3_cs", int'(flash_cs), 0);
    check("retry3_we", int'(mem_we), 0);
    check("retry3_loading", int'(loading), 1);
    check("retry3_done", int'(done), 0);
    check("retry3_count", wr_idx, 5);
    hang_next = 1;
    kick();
    wait_end(3000);
    check("hang_error", int'(error), 1);
    check("hang_count", wr_idx, 0);
    repeat (20) @(posedge clk);
    kick();
    wait_end(3000);
    check_done("after_hang");
    kick();
    n = 0;
    while (wr_idx < 9 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte9", wr_idx, 9);
    repeat (4) @(posedge clk);
    #3 resetn = 1'b0;
    #1 check_reset("async_rst");
    wr_idx = 0;
    @(posedge clk);
    #2 resetn = 1'b1;
    wait_end(3000);
    check_done("restart");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
